decode_stage: RTL and testbench

Pipelined instruction-decode stage for the single-issue MIPS-subset datapath. It accepts one 32-bit instruction per cycle from fetch and decodes control and ALU-control. It reads operands from an internal parametrised register file with write-through bypass and detects load-use hazards, inserting a bubble when one occurs. All results are registered into an ID/EX pipeline register that feeds execute.

---
 rtl/decode_stage.sv | 244 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: MIPS-subset instruction decode with register file,
// write-through bypass, load-use stall and registered ID/EX outputs.
module decode_stage #(
  parameter  int DATA_W = 32,
  parameter  int NREG   = 32,
  localparam int RA_W   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_mem_to_reg,
  output logic              out_alu_src,
  output logic              out_branch,
  output logic              out_jump,
  output logic              out_jr,
  output logic [2:0]        out_alu_ctrl,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [4:0]        out_shamt,
  output logic [RA_W-1:0]   out_wreg,
  output logic [31:0]       out_jtarget,
  output logic              out_illegal
);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BGT = 6'b000111;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_SLL  = 3'b111;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       jr;
    logic       illegal;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  logic [5:0]      op;
  logic [5:0]      funct;
  logic [RA_W-1:0] rs_idx;
  logic [RA_W-1:0] rt_idx;
  logic [RA_W-1:0] rd_idx;

  assign op     = in_instr[31:26];
  assign funct  = in_instr[5:0];
  assign rs_idx = in_instr[21 +: RA_W];
  assign rt_idx = in_instr[16 +: RA_W];
  assign rd_idx = in_instr[11 +: RA_W];

  logic unused_ok;
  assign unused_ok = ^{in_pc[27:0], in_instr};

  logic [DATA_W-1:0] regs_q [NREG];

  ctrl_t             ctrl_d, ctrl_q;
  logic              valid_d, valid_q;
  logic [RA_W-1:0]   wreg_d, wreg_q;
  logic              uses_rt;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic [DATA_W-1:0] rs_q, rt_q, imm_q;
  logic [DATA_W-1:0] imm_d;
  logic [4:0]        shamt_q;
  logic [31:0]       jtgt_d, jtgt_q;
  logic              hazard;
  logic              load;

  // Decode opcode/funct into control bits, ALU op and destination.
  always_comb begin
    ctrl_d  = '0;
    wreg_d  = '0;
    uses_rt = 1'b0;
    unique case (op)
      OP_R: begin
        uses_rt = 1'b1;
        unique case (funct)
          FN_ADD: ctrl_d.alu_ctrl = ALU_ADD;
          FN_SUB: ctrl_d.alu_ctrl = ALU_SUB;
          FN_AND: ctrl_d.alu_ctrl = ALU_AND;
          FN_OR:  ctrl_d.alu_ctrl = ALU_OR;
          FN_XOR: ctrl_d.alu_ctrl = ALU_XOR;
          FN_SLT: ctrl_d.alu_ctrl = ALU_SLT;
          FN_SLL: ctrl_d.alu_ctrl = ALU_SLL;
          FN_JR:  ctrl_d.jr       = 1'b1;
          default: ctrl_d.illegal = 1'b1;
        endcase
        if (!ctrl_d.illegal && !ctrl_d.jr) begin
          ctrl_d.reg_write = 1'b1;
          wreg_d           = rd_idx;
        end
      end
      OP_LW: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.alu_ctrl   = ALU_ADD;
        wreg_d            = rt_idx;
      end
      OP_SW: begin
        uses_rt          = 1'b1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_ctrl  = ALU_ADD;
      end
      OP_BGT: begin
        uses_rt         = 1'b1;
        ctrl_d.branch   = 1'b1;
        ctrl_d.alu_ctrl = ALU_SUB;
      end
      OP_J: begin
        ctrl_d.jump = 1'b1;
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
  end

  // Register file read ports; r0 is hardwired zero, writeback bypasses.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs_idx != '0) begin
      if (wb_en && wb_addr == rs_idx) rs_val = wb_data;
      else                            rs_val = regs_q[rs_idx];
    end
    if (rt_idx != '0) begin
      if (wb_en && wb_addr == rt_idx) rt_val = wb_data;
      else                            rt_val = regs_q[rt_idx];
    end
  end

  assign imm_d  = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
  assign jtgt_d = {in_pc[31:28], in_instr[25:0], 2'b00};

  // Load-use: a load in ID/EX targets a register this instruction reads.
  always_comb begin
    hazard = 1'b0;
    if (valid_q && ctrl_q.mem_read && wreg_q != '0) begin
      if (wreg_q == rs_idx)             hazard = 1'b1;
      if (uses_rt && wreg_q == rt_idx)  hazard = 1'b1;
    end
  end

  assign in_ready = flush | ~hazard;
  assign load     = in_valid & ~hazard & ~flush;
  assign valid_d  = load;

  // Register array: cleared on reset, r0 writes dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // ID/EX control: bubble clears valid and every enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      wreg_q  <= '0;
    end else if (load) begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      wreg_q  <= wreg_d;
    end else begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      wreg_q  <= '0;
    end
  end

  // ID/EX data: held across bubbles so the outputs stay stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      shamt_q <= '0;
      jtgt_q  <= '0;
    end else if (load) begin
      rs_q    <= rs_val;
      rt_q    <= rt_val;
      imm_q   <= imm_d;
      shamt_q <= in_instr[10:6];
      jtgt_q  <= jtgt_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_reg_write  = ctrl_q.reg_write;
  assign out_mem_read   = ctrl_q.mem_read;
  assign out_mem_write  = ctrl_q.mem_write;
  assign out_mem_to_reg = ctrl_q.mem_to_reg;
  assign out_alu_src    = ctrl_q.alu_src;
  assign out_branch     = ctrl_q.branch;
  assign out_jump       = ctrl_q.jump;
  assign out_jr         = ctrl_q.jr;
  assign out_illegal    = ctrl_q.illegal;
  assign out_alu_ctrl   = ctrl_q.alu_ctrl;
  assign out_rs_data    = rs_q;
  assign out_rt_data    = rt_q;
  assign out_imm        = imm_q;
  assign out_shamt      = shamt_q;
  assign out_wreg       = wreg_q;
  assign out_jtarget    = jtgt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors with hand-computed expectations
// for decode_stage.
module tb_decode_stage;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int RA_W   = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [31:0]       in_pc;
  logic              wb_en;
  logic [RA_W-1:0]   wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              out_valid;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_mem_to_reg;
  logic              out_alu_src;
  logic              out_branch;
  logic              out_jump;
  logic              out_jr;
  logic [2:0]        out_alu_ctrl;
  logic [DATA_W-1:0] out_rs_data;
  logic [DATA_W-1:0] out_rt_data;
  logic [DATA_W-1:0] out_imm;
  logic [4:0]        out_shamt;
  logic [RA_W-1:0]   out_wreg;
  logic [31:0]       out_jtarget;
  logic              out_illegal;

  int total = 0;
  int bad   = 0;

  decode_stage #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid),
    .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write),
    .out_mem_to_reg(out_mem_to_reg),
    .out_alu_src(out_alu_src),
    .out_branch(out_branch),
    .out_jump(out_jump),
    .out_jr(out_jr),
    .out_alu_ctrl(out_alu_ctrl),
    .out_rs_data(out_rs_data),
    .out_rt_data(out_rt_data),
    .out_imm(out_imm),
    .out_shamt(out_shamt),
    .out_wreg(out_wreg),
    .out_jtarget(out_jtarget),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    #1;
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt,
                                        input int rd, input int sh,
                                        input logic [5:0] fn);
    logic [31:0] w;
    w = {6'b0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn};
    return w;
  endfunction

  function automatic logic [6:0] ens();
    return {out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
            out_branch, out_jump, out_jr};
  endfunction

  localparam logic [31:0] LW_R2 = 32'h8C22FFFC;
  localparam logic [31:0] ADD_H = 32'h00412020;

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_instr = 32'h00A51820;
    in_pc = '0; flush = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_ens", ens(), 0);
    chk("rst_rs", out_rs_data, 0);
    reset = 1'b0; wb_en = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);

    for (int i = 1; i < NREG; i++) begin
      drive(rtype(i, i, 1, 0, 6'h20));
      tick();
      chk("clr_rd", {out_rs_data, out_rt_data}, 0);
    end
    chk("clr_valid", out_valid, 1);

    in_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    tick();
    wb_addr = 5'd1; wb_data = 32'h100;
    tick();
    wb_en = 1'b0;
    chk("bubble_noval", out_valid, 0);

    drive(32'h00A51820);
    tick();
    chk("add_valid", out_valid, 1);
    chk("add_rw", out_reg_write, 1);
    chk("add_alu", out_alu_ctrl, 3'b001);
    chk("add_wreg", out_wreg, 3);
    chk("add_rs", out_rs_data, 32'h1234);
    chk("add_rt", out_rt_data, 32'h1234);
    chk("add_src", out_alu_src, 0);

    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hBEEF;
    drive(32'h00A51820);
    tick();
    wb_en = 1'b0;
    chk("byp_rs", out_rs_data, 32'hBEEF);
    chk("byp_rt", out_rt_data, 32'hBEEF);

    drive(LW_R2);
    tick();
    chk("lw_ens", ens(), 7'b1101000);
    chk("lw_src", out_alu_src, 1);
    chk("lw_alu", out_alu_ctrl, 3'b001);
    chk("lw_wreg", out_wreg, 2);
    chk("lw_imm", out_imm, 32'hFFFFFFFC);
    chk("lw_rs", out_rs_data, 32'h100);
    drive(ADD_H);
    chk("stall_rdy", in_ready, 0);
    tick();
    chk("stall_bub", out_valid, 0);
    chk("stall_ens", ens(), 0);
    chk("stall_rdy2", in_ready, 1);
    tick();
    chk("stall_iss", out_valid, 1);
    chk("stall_wreg", out_wreg, 4);
    in_valid = 1'b0;
    tick();
    chk("iss_once", out_valid, 0);

    drive(LW_R2);
    tick();
    drive(32'h00212020);
    chk("nostall_rdy", in_ready, 1);
    tick();
    chk("nostall_v", out_valid, 1);
    chk("nostall_w", out_wreg, 4);

    drive(32'hAC220008);
    tick();
    chk("sw_ens", ens(), 7'b0010000);
    chk("sw_src", out_alu_src, 1);
    chk("sw_alu", out_alu_ctrl, 3'b001);

    drive(32'h1C220004);
    tick();
    chk("bgt_ens", ens(), 7'b0000100);
    chk("bgt_alu", out_alu_ctrl, 3'b010);
    chk("bgt_src", out_alu_src, 0);

    in_pc = 32'h40000004;
    drive(32'h08000100);
    tick();
    chk("j_ens", ens(), 7'b0000010);
    chk("j_tgt", out_jtarget, 32'h40000400);
    in_pc = '0;

    drive(32'h00200008);
    tick();
    chk("jr_ens", ens(), 7'b0000001);
    chk("jr_alu", out_alu_ctrl, 3'b000);

    drive(32'h00011900);
    tick();
    chk("sll_alu", out_alu_ctrl, 3'b111);
    chk("sll_sh", out_shamt, 4);
    chk("sll_w", out_wreg, 3);

    drive(32'hFC000000);
    tick();
    chk("ill_valid", out_valid, 1);
    chk("ill_flag", out_illegal, 1);
    chk("ill_ens", ens(), 0);

    drive(rtype(1, 1, 3, 0, 6'h3F));
    tick();
    chk("illfn_flag", out_illegal, 1);
    chk("illfn_ens", ens(), 0);

    in_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    tick();
    drive(32'h00001820);
    tick();
    wb_en = 1'b0;
    chk("r0_zero", {out_rs_data, out_rt_data}, 0);

    drive(LW_R2);
    tick();
    drive(ADD_H);
    flush = 1'b1;
    #1;
    chk("fl_rdy", in_ready, 1);
    tick();
    flush = 1'b0;
    chk("fl_bub", out_valid, 0);
    chk("fl_ens", ens(), 0);
    tick();
    chk("fl_iss", out_valid, 1);
    chk("fl_w", out_wreg, 4);

    drive(LW_R2);
    tick();
    drive(ADD_H);
    chk("rs_stall", in_ready, 0);
    reset = 1'b1;
    tick();
    chk("rs_valid", out_valid, 0);
    chk("rs_ens", ens(), 0);
    chk("rs_data", {out_rs_data, out_rt_data}, 0);
    chk("rs_wreg", out_wreg, 0);
    chk("rs_imm", out_imm, 0);
    reset = 1'b0;
    drive(rtype(5, 7, 3, 0, 6'h20));
    chk("rs_rdy", in_ready, 1);
    tick();
    chk("rs_clr", {out_rs_data, out_rt_data}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
